// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - opcode and FSM state types shared by alu_mc and alu_mc_iter
package alu_mc_pkg;

  localparam logic [2:0] SEL_ADD = 3'b000;
  localparam logic [2:0] SEL_SUB = 3'b001;
  localparam logic [2:0] SEL_AND = 3'b010;
  localparam logic [2:0] SEL_OR  = 3'b011;
  localparam logic [2:0] SEL_NOT = 3'b100;
  localparam logic [2:0] SEL_SHL = 3'b101;
  localparam logic [2:0] SEL_SHR = 3'b110;
  localparam logic [2:0] SEL_MUL = 3'b111;

  typedef enum logic [2:0] {
    OP_ADD = SEL_ADD,
    OP_SUB = SEL_SUB,
    OP_AND = SEL_AND,
    OP_OR  = SEL_OR,
    OP_NOT = SEL_NOT,
    OP_SHL = SEL_SHL,
    OP_SHR = SEL_SHR,
    OP_MUL = SEL_MUL
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// rtl/alu_mc_iter.sv - one-step-per-cycle shifter / shift-add multiplier (multiplier only with ALU_MC_MUL_EN)
module alu_mc_iter
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   k,
  output logic             done,
  output logic [WIDTH-1:0] res_nxt,
  output logic             c_nxt,
  output logic             v_nxt
);

  localparam int CW = SHW + 1;

  logic [CW-1:0]    cnt;
  logic [2:0]       mode;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;

`ifdef ALU_MC_MUL_EN
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   mq;
`else
  logic unused_b;
  assign unused_b = ^b;
`endif

  // the step taken in the current cycle is the last one when one step remains
  assign done = (cnt == CW'(1));

  // state after the step of this cycle; the top captures it on the final step
  always_comb begin
    sr_nxt  = sr;
    res_nxt = sr;
    c_nxt   = 1'b0;
    v_nxt   = 1'b0;
`ifdef ALU_MC_MUL_EN
    acc_nxt = mq[0] ? (acc + mcand) : acc;
`endif
    case (mode)
      SEL_SHL: begin
        sr_nxt  = {sr[WIDTH-2:0], 1'b0};
        res_nxt = {sr[WIDTH-2:0], 1'b0};
        c_nxt   = sr[WIDTH-1];
      end
      SEL_SHR: begin
        sr_nxt  = {1'b0, sr[WIDTH-1:1]};
        res_nxt = {1'b0, sr[WIDTH-1:1]};
        c_nxt   = sr[0];
      end
`ifdef ALU_MC_MUL_EN
      SEL_MUL: begin
        res_nxt = acc_nxt[WIDTH-1:0];
        c_nxt   = |acc_nxt[2*WIDTH-1:WIDTH];
        v_nxt   = |acc_nxt[2*WIDTH-1:WIDTH];
      end
`endif
      default: ;
    endcase
  end

  // load operands on start, then advance one step per cycle until the count runs out
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      mode  <= '0;
      sr    <= '0;
`ifdef ALU_MC_MUL_EN
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
`endif
    end else if (start) begin
      mode  <= op;
      sr    <= a;
      cnt   <= (op == SEL_MUL) ? CW'(WIDTH) : CW'(k);
`ifdef ALU_MC_MUL_EN
      mcand <= {{WIDTH{1'b0}}, a};
      acc   <= '0;
      mq    <= b;
`endif
    end else if (cnt != '0) begin
      cnt   <= cnt - CW'(1);
      sr    <= sr_nxt;
`ifdef ALU_MC_MUL_EN
      mcand <= mcand << 1;
      acc   <= acc_nxt;
      mq    <= mq >> 1;
`endif
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake; define ALU_MC_MUL_EN to include the multiplier
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             n
);

  state_e state;
  state_e state_nxt;
  op_e    op;

  logic [SHW-1:0]   k;
  logic             iter_op;
  logic             start;
  logic             load_now;
  logic             load_iter;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r1;
  logic             c1;
  logic             v1;
  logic             iter_done;
  logic [WIDTH-1:0] iter_res;
  logic             iter_c;
  logic             iter_v;

  assign op   = op_e'(sel);
  assign k    = opB[SHW-1:0];
  assign sum  = {1'b0, opA} + {1'b0, opB};
  assign diff = {1'b0, opA} - {1'b0, opB};

`ifdef ALU_MC_MUL_EN
  assign iter_op = (((op == OP_SHL) || (op == OP_SHR)) && (k != '0)) || (op == OP_MUL);
`else
  assign iter_op = ((op == OP_SHL) || (op == OP_SHR)) && (k != '0);
`endif

  // result and flags of every op that completes on the accepting edge
  always_comb begin
    r1 = '0;
    c1 = 1'b0;
    v1 = 1'b0;
    case (op)
      OP_ADD: begin
        r1 = sum[WIDTH-1:0];
        c1 = sum[WIDTH];
        v1 = (opA[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != opA[WIDTH-1]);
      end
      OP_SUB: begin
        r1 = diff[WIDTH-1:0];
        c1 = ~diff[WIDTH];
        v1 = (opA[WIDTH-1] != opB[WIDTH-1]) && (diff[WIDTH-1] != opA[WIDTH-1]);
      end
      OP_AND: r1 = opA & opB;
      OP_OR:  r1 = opA | opB;
      OP_NOT: r1 = ~opA;
      OP_SHL: r1 = opA;
      OP_SHR: r1 = opA;
      OP_MUL: r1 = '0;
    endcase
  end

  alu_mc_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (sel),
    .a       (opA),
    .b       (opB),
    .k       (k),
    .done    (iter_done),
    .res_nxt (iter_res),
    .c_nxt   (iter_c),
    .v_nxt   (iter_v)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state, handshake outputs and datapath load strobes
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load_now  = 1'b0;
    load_iter = 1'b0;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (iter_op) begin
            start     = 1'b1;
            state_nxt = BUSY;
          end else begin
            load_now  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      BUSY: begin
        if (iter_done) begin
          load_iter = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // result and flag registers, held unchanged while the result waits in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      z   <= 1'b0;
      c   <= 1'b0;
      v   <= 1'b0;
      n   <= 1'b0;
    end else if (load_now) begin
      res <= r1;
      z   <= (r1 == '0);
      c   <= c1;
      v   <= v1;
      n   <= r1[WIDTH-1];
    end else if (load_iter) begin
      res <= iter_res;
      z   <= (iter_res == '0);
      c   <= iter_c;
      v   <= iter_v;
      n   <= iter_res[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized self-checking bench for alu_mc against a behavioural model
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic [2:0]   sel = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] res;
  logic         z;
  logic         c;
  logic         v;
  logic         n;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opA       (opA),
    .opB       (opB),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .z         (z),
    .c         (c),
    .v         (v),
    .n         (n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rdy_mode = 2;
  bit   chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [63:0]  wide;
    int           k;
    k     = int'(b[4:0]);
    e.res = '0;
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.lat = 1;
    e.acc = 0;
    wide  = '0;
    case (s)
      3'd0: begin
        wide  = 64'(a) + 64'(b);
        e.res = wide[31:0];
        e.c   = wide[32];
        e.v   = (a[31] == b[31]) && (e.res[31] != a[31]);
      end
      3'd1: begin
        e.res = a - b;
        e.c   = (a >= b);
        e.v   = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = ~a;
      3'd5: begin
        e.res = a << k;
        e.c   = (k != 0) ? a[W-k] : 1'b0;
        e.lat = k + 1;
      end
      3'd6: begin
        e.res = a >> k;
        e.c   = (k != 0) ? a[k-1] : 1'b0;
        e.lat = k + 1;
      end
      default: begin
`ifdef ALU_MC_MUL_EN
        wide  = 64'(a) * 64'(b);
        e.res = wide[31:0];
        e.c   = (wide[63:32] != 32'd0);
        e.v   = e.c;
        e.lat = W + 1;
`endif
      end
    endcase
    e.z = (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  // compare process: handshake timing every cycle, result and flags while a result is due
  always @(negedge clk) begin
    bit ev;
    bit er;
    if (chk_en) begin
      er = (q.size() == 0);
      ev = 1'b0;
      if (q.size() != 0) ev = ((cyc - q[0].acc + 1) >= q[0].lat);
      chk("in_ready", 64'(in_ready), 64'(er));
      chk("out_valid", 64'(out_valid), 64'(ev));
      if (ev && out_valid) begin
        chk("res", 64'(res), 64'(q[0].res));
        chk("flag_z", 64'(z), 64'(q[0].z));
        chk("flag_c", 64'(c), 64'(q[0].c));
        chk("flag_v", 64'(v), 64'(q[0].v));
        chk("flag_n", 64'(n), 64'(q[0].n));
      end
      if (ev && out_ready) void'(q.pop_front());
    end
  end

  // consumer: random backpressure, forced low or forced high
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic issue(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    bit   took;
    exp_t e;
    took     = 1'b0;
    sel      = s;
    opA      = a;
    opB      = b;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !took; t++) begin
      @(negedge clk);
      took = in_ready && !rst;
      @(posedge clk);
      #1;
    end
    if (took) begin
      e     = model(s, a, b);
      e.acc = cyc;
      q.push_back(e);
    end else begin
      chk("accept_timeout", 64'(0), 64'(1));
    end
    in_valid = 1'b0;
    opA      = $urandom;
    opB      = $urandom;
    sel      = 3'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && q.size() != 0; t++) @(posedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'(0));
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] xr, input logic xc, input logic xv, input logic xz,
                     input logic xn, input int xl);
    exp_t e;
    e = model(s, a, b);
    chk({nm, "_model_res"}, 64'(e.res), 64'(xr));
    chk({nm, "_model_c"}, 64'(e.c), 64'(xc));
    chk({nm, "_model_v"}, 64'(e.v), 64'(xv));
    chk({nm, "_model_z"}, 64'(e.z), 64'(xz));
    chk({nm, "_model_n"}, 64'(e.n), 64'(xn));
    chk({nm, "_model_lat"}, 64'(e.lat), 64'(xl));
    issue(s, a, b);
    drain();
  endtask

  task automatic chk_cleared(input string nm);
    @(negedge clk);
    chk({nm, "_res"}, 64'(res), 64'(0));
    chk({nm, "_z"}, 64'(z), 64'(0));
    chk({nm, "_c"}, 64'(c), 64'(0));
    chk({nm, "_v"}, 64'(v), 64'(0));
    chk({nm, "_n"}, 64'(n), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;

    // request offered while in reset must be ignored
    rst      = 1'b1;
    in_valid = 1'b1;
    sel      = 3'd0;
    opA      = 32'd1;
    opB      = 32'd2;
    repeat (3) @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk_en   = 1'b1;
    chk_cleared("reset");
    @(posedge clk);
    #1;

    rdy_mode = 2;
    lit("add_ovf", 3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    lit("sub_eq",  3'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    lit("sub_neg", 3'd1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    lit("shl_1",   3'd5, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    lit("shr_0",   3'd6, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    lit("shr_k0hi", 3'd6, 32'h8765_4321, 32'hFFFF_FFE0, 32'h8765_4321, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    lit("shr_31",  3'd6, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32);
`ifdef ALU_MC_MUL_EN
    lit("mul_hi",  3'd7, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 33);
`else
    lit("mul_off", 3'd7, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
`endif

    // backpressure: result held for 5 stalled cycles while a new request waits
    rdy_mode = 1;
    issue(3'd0, 32'h0000_0011, 32'h0000_0022);
    sel      = 3'd1;
    opA      = 32'h0000_0100;
    opB      = 32'h0000_0001;
    in_valid = 1'b1;
    for (int t = 0; t < 10 && !out_valid; t++) @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_res_hold", 64'(res), 64'(32'h0000_0033));
    end
    rdy_mode = 2;
    issue(3'd1, 32'h0000_0100, 32'h0000_0001);
    drain();

    // reset in the 10th busy cycle aborts the iterative request
`ifdef ALU_MC_MUL_EN
    issue(3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
`else
    issue(3'd5, 32'hDEAD_BEEF, 32'h0000_001F);
`endif
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    rst = 1'b0;
    chk_cleared("abort");
    repeat (40) @(negedge clk);
    @(posedge clk);
    #1;
    lit("add_after_rst", 3'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // randomized traffic with random backpressure
    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      s = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(0, 15));
        2:       a = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
        default: a = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
      endcase
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(0, 15));
        2:       b = a;
        default: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      endcase
      if (s == 3'd5 || s == 3'd6) b = {$urandom_range(0, 1) != 0 ? 27'($urandom) : 27'd0, 5'($urandom_range(0, 31))};
      issue(s, a, b);
      if ($urandom_range(0, 7) == 0) drain();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), width of the shift-amount field taken from opB.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, request valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port opA, input, WIDTH, first operand.
REQ-008 SHALL have port opB, input, WIDTH, second operand; for shifts only opB[SHW-1:0] is used.
REQ-009 SHALL have port sel, input, 3, opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT opA, 101 SHL, 110 SHR (logical), 111 MUL (low WIDTH bits).
REQ-010 SHALL have port out_valid, output, 1, result and flags valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port res, output, WIDTH, result.
REQ-013 SHALL have ports z, c, v, n, output, 1 each: zero, carry, overflow and negative flags.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 SHALL accept a request on the edge where in_valid && in_ready, capturing opA, opB and sel; inputs outside that edge are ignored.
REQ-016 SHALL, for ADD/SUB/AND/OR/NOT, move IDLE->DONE on acceptance; out_valid is high in the first cycle after acceptance (latency 1).
REQ-017 SHALL, for SHL/SHR with k=opB[SHW-1:0], shift one bit per BUSY cycle: k=0 goes IDLE->DONE (latency 1); k>0 goes IDLE->BUSY and reaches DONE after k BUSY cycles (latency k+1).
REQ-018 SHALL, for MUL, perform one shift-add step per BUSY cycle for WIDTH cycles (latency WIDTH+1), and its result equals (opA*opB) mod 2^WIDTH.
REQ-019 SHALL hold res and the flags stable in DONE until out_valid && out_ready, then go to IDLE; in_ready is not asserted in that same cycle.
REQ-020 SHALL compute z = (res==0) and n = res[WIDTH-1] for every opcode.
REQ-021 SHALL set the ADD flags as follows: c = carry out of bit WIDTH-1; v = 1 when the operand signs are equal and the result sign differs.
REQ-022 SHALL set the SUB flags as follows: c = 1 when opA >= opB unsigned (no borrow); v = 1 when the operand signs differ and the result sign differs from opA.
REQ-023 SHALL set c = 0 and v = 0 for AND/OR/NOT.
REQ-024 SHALL set c = last bit shifted out for SHL/SHR (0 when k=0), with v = 0.
REQ-025 SHALL set c = v = 1 for MUL when the full 2*WIDTH-bit product has nonzero upper half, and 0 otherwise.

Reset
REQ-026 SHALL, when rst is high at a clock edge, go to IDLE and clear res, z, c, v, n and all internal counters and accumulators; out_valid=0 and in_ready=1 from the next cycle.
REQ-027 SHALL abort an operation in BUSY or DONE when rst is asserted, with no result presented afterwards.
REQ-028 SHALL ignore in_valid in any cycle where rst is high.

Configuration
REQ-029 SHALL, with macro ALU_MC_MUL_EN defined, implement MUL as in REQ-018 and REQ-025.
REQ-030 SHALL, without ALU_MC_MUL_EN, omit the multiplier datapath and treat sel=111 as a latency-1 op with res=0, z=1, c=v=n=0.

Structure
REQ-031 SHALL place the opcode enum (3-bit), the FSM state enum and the opcode localparams in shared package alu_mc_pkg.
REQ-032 SHALL implement shift/multiply iteration in sub-module alu_mc_iter (start/done handshake, step counter, shift register/accumulator), instantiated once by alu_mc.

Verification
REQ-033 SHALL verify ADD 0x7FFFFFFF+0x00000001 -> res=0x80000000, v=1, c=0, n=1, z=0, out_valid one cycle after acceptance.
REQ-034 SHALL verify SUB 0x00000005-0x00000005 -> res=0, z=1, c=1, v=0; SUB 0x3-0x5 -> res=0xFFFFFFFE, c=0, n=1.
REQ-035 SHALL verify SHL opA=0x80000001, opB=1 -> res=0x00000002, c=1, latency 2; SHR opB=0 -> res=opA, c=0, latency 1.
REQ-036 SHALL verify MUL 0x00010000*0x00010000 with ALU_MC_MUL_EN -> res=0, z=1, c=v=1, latency 33; without the macro -> res=0, z=1, c=v=0, latency 1.
REQ-037 SHALL verify backpressure: out_ready held low for 5 cycles -> res/flags stable, in_ready=0, new in_valid not accepted; accepted only after the out_valid&&out_ready cycle.
REQ-038 SHALL verify that rst pulsed in the 10th BUSY cycle of a MUL -> IDLE next cycle, out_valid never asserted for that request, and the next ADD 2+3 -> res=5.
